// File: rtl/uart_tx_if.sv
// Handshake bundle between a word producer and the UART transmitter.
// The producer (master) offers words with tx_start/tx_data; the transmitter
// (slave) reports holding-register space, frame activity and frame completion.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done_tick;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional
// parity bit, then STOP_TICKS ticks of stop level. Bit timing is counted in
// 16x-oversampling s_tick pulses. A one-word holding register lets the next
// word queue up while the current frame shifts out, so frames run back to
// back with a single clk of idle level between them.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_TICKS = 16
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     s_tick,
    uart_tx_if.slave bus,
    output logic     tx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [4:0] BIT_TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST     = 5'(STOP_TICKS - 1);
    localparam logic [2:0] BIT_LAST      = 3'(DATA_BITS - 1);

    // Odd parity starts the accumulator at 1 so that the transmitted parity
    // bit makes the total count of ones odd; even parity starts at 0.
    function automatic logic parity_seed();
        return 1'(PARITY == 2);
    endfunction

    state_t               state, state_n;
    logic [4:0]           tick_cnt, tick_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] hold_data, hold_data_n;
    logic                 hold_valid, hold_valid_n;
    logic                 par_acc, par_n;
    logic                 tx_reg, tx_n;
    logic                 done_reg, done_n;
    logic                 accept;

    assign accept           = bus.tx_start && !hold_valid;
    assign bus.tx_ready     = ~hold_valid;
    assign bus.tx_busy      = (state != S_IDLE);
    assign bus.tx_done_tick = done_reg;
    assign tx               = tx_reg;

    // Next-state, counter, shifter and holding-register logic; the line level
    // is derived from the next state so tx changes on the edge entering a bit.
    always_comb begin
        state_n      = state;
        tick_n       = tick_cnt;
        bit_n        = bit_cnt;
        shift_n      = shift_reg;
        par_n        = par_acc;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        done_n       = 1'b0;
        tx_n         = 1'b1;

        case (state)
            S_IDLE: begin
                // A tick coinciding with the load edge is deliberately dropped.
                if (hold_valid) begin
                    shift_n      = hold_data;
                    hold_valid_n = 1'b0;
                    tick_n       = '0;
                    bit_n        = '0;
                    par_n        = parity_seed();
                    state_n      = S_START;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_n  = '0;
                        state_n = S_DATA;
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = shift_reg >> 1;
                        par_n   = par_acc ^ shift_reg[0];
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_n  = '0;
                        state_n = S_STOP;
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_n  = '0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Accept only while the holding register is empty in this cycle; the
        // IDLE load above never coincides with an accept for the same reason.
        if (accept) begin
            hold_valid_n = 1'b1;
            hold_data_n  = bus.tx_data;
        end

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

    // Control registers: state, counters, holding flag and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            hold_valid <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            bit_cnt    <= bit_n;
            hold_valid <= hold_valid_n;
            tx_reg     <= tx_n;
            done_reg   <= done_n;
        end
    end

    // Data registers: only meaningful when qualified by the control state.
    always_ff @(posedge clk) begin
        shift_reg <= shift_n;
        hold_data <= hold_data_n;
        par_acc   <= par_n;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three transmitters with different framing driven by the
// same word stream, a frame-level reference model, a tick-driven receiver on
// the 8N1 line and directed literal checks of timing and parity.
module tb_uart_tx;

    localparam int N = 3;
    localparam int DB [N] = '{8, 8, 7};
    localparam int PB [N] = '{0, 1, 2};
    localparam int SB [N] = '{16, 24, 32};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_tick = 1'b0;
    logic start_all = 1'b0;
    logic [7:0] din = 8'h00;
    logic tx0, tx1, tx2;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(7)) bus2 ();

    assign bus0.tx_start = start_all;
    assign bus1.tx_start = start_all;
    assign bus2.tx_start = start_all;
    assign bus0.tx_data  = din;
    assign bus1.tx_data  = din;
    assign bus2.tx_data  = din[6:0];

    uart_tx #(.DATA_BITS(DB[0]), .PARITY(PB[0]), .STOP_TICKS(SB[0])) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus0.slave), .tx(tx0));
    uart_tx #(.DATA_BITS(DB[1]), .PARITY(PB[1]), .STOP_TICKS(SB[1])) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus1.slave), .tx(tx1));
    uart_tx #(.DATA_BITS(DB[2]), .PARITY(PB[2]), .STOP_TICKS(SB[2])) dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus2.slave), .tx(tx2));

    always #5 clk = ~clk;

    logic [3:0] obs [N];
    assign obs[0] = {tx0, bus0.tx_ready, bus0.tx_busy, bus0.tx_done_tick};
    assign obs[1] = {tx1, bus1.tx_ready, bus1.tx_busy, bus1.tx_done_tick};
    assign obs[2] = {tx2, bus2.tx_ready, bus2.tx_busy, bus2.tx_done_tick};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick source: 0 = every 4th clk, 1 = random, 2 = every clk.
    int mode = 0;
    int tdiv = 0;
    always @(posedge clk) begin
        #1;
        tdiv = (tdiv + 1) % 4;
        case (mode)
            0:       s_tick = (tdiv == 0);
            1:       s_tick = ($urandom_range(0, 1) == 1);
            default: s_tick = 1'b1;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Frame contents as a bit list: start, data LSB-first, parity from the
    // count of ones in the data word.
    function automatic logic [9:0] make_frame(input int k, input logic [7:0] d);
        logic [7:0] m;
        logic [9:0] f;
        int ones;
        m = d & 8'((1 << DB[k]) - 1);
        ones = $countones(m);
        f = '0;
        for (int i = 0; i < DB[k]; i++) f[1 + i] = m[i];
        if (PB[k] == 1) f[1 + DB[k]] = (ones % 2 == 1);
        if (PB[k] == 2) f[1 + DB[k]] = (ones % 2 == 0);
        return f;
    endfunction

    // Reference model: a frame is a bit list plus an elapsed-tick count.
    logic       m_act [N];
    logic       m_hv  [N];
    logic [7:0] m_hd  [N];
    logic [9:0] m_fr  [N];
    int         m_nb  [N];
    int         m_tot [N];
    int         m_el  [N];
    logic       m_done[N];
    logic       m_tx  [N];
    logic       m_acc;
    logic [7:0] exp_q [$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                m_act[k] = 1'b0; m_hv[k] = 1'b0; m_el[k] = 0;
                m_done[k] = 1'b0; m_tx[k] = 1'b1;
            end
            exp_q.delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                m_acc = start_all && !m_hv[k];
                m_done[k] = 1'b0;
                if (!m_act[k]) begin
                    if (m_hv[k]) begin
                        m_fr[k]  = make_frame(k, m_hd[k]);
                        m_nb[k]  = 1 + DB[k] + ((PB[k] != 0) ? 1 : 0);
                        m_tot[k] = 16 * m_nb[k] + SB[k];
                        m_el[k]  = 0;
                        m_act[k] = 1'b1;
                        m_hv[k]  = 1'b0;
                        if (k == 0) exp_q.push_back(m_hd[0]);
                    end
                end else if (s_tick) begin
                    m_el[k]++;
                    if (m_el[k] == m_tot[k]) begin
                        m_act[k]  = 1'b0;
                        m_done[k] = 1'b1;
                    end
                end
                if (m_acc) begin
                    m_hv[k] = 1'b1;
                    m_hd[k] = din;
                end
                if (!m_act[k]) m_tx[k] = 1'b1;
                else if (m_el[k] / 16 < m_nb[k]) m_tx[k] = m_fr[k][m_el[k] / 16];
                else m_tx[k] = 1'b1;
            end
        end
    end

    // Every cycle: all outputs of every transmitter against the model.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++)
            check($sformatf("model dut%0d {tx,ready,busy,done}", k), 32'(obs[k]),
                  32'({m_tx[k], !m_hv[k], m_act[k], m_done[k]}));
    end

    // Receiver on the 8N1 line, sampling mid-bit from s_tick counts.
    int rx_st = 0, rx_cnt = 0, rx_n = 0, rx_count = 0;
    logic [7:0] rx_sh = 8'h00;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st = 0; rx_cnt = 0; rx_n = 0;
        end else if (s_tick) begin
            case (rx_st)
                0: if (tx0 == 1'b0) begin rx_st = 1; rx_cnt = 0; end
                1: begin
                    rx_cnt++;
                    if (rx_cnt == 8) begin
                        if (tx0 == 1'b0) begin rx_st = 2; rx_cnt = 0; rx_n = 0; end
                        else rx_st = 0;
                    end
                end
                2: begin
                    rx_cnt++;
                    if (rx_cnt == 16) begin
                        rx_sh = {tx0, rx_sh[7:1]};
                        rx_cnt = 0;
                        rx_n++;
                        if (rx_n == 8) rx_st = 3;
                    end
                end
                default: begin
                    rx_cnt++;
                    if (rx_cnt == 16) begin
                        check("rx stop level", 32'(tx0), 32'd1);
                        if (exp_q.size() == 0) check("rx unexpected word", 32'(rx_sh), 32'hFFFF_FFFF);
                        else check("rx data", 32'(rx_sh), 32'(exp_q.pop_front()));
                        rx_count++;
                        rx_st = 0;
                    end
                end
            endcase
        end
    end

    // Edge monitors for the 8N1 transmitter.
    int d0_done [$];
    int d0_rise [$];
    logic b0_prev = 1'b0;
    always @(negedge clk) begin
        if (bus0.tx_done_tick === 1'b1) d0_done.push_back(cyc);
        if (bus0.tx_busy === 1'b1 && !b0_prev) d0_rise.push_back(cyc);
        b0_prev = (bus0.tx_busy === 1'b1);
    end

    task automatic wait_ready_all();
        int n = 0;
        @(posedge clk); #2;
        while (!(bus0.tx_ready && bus1.tx_ready && bus2.tx_ready)) begin
            @(posedge clk); #2;
            n++;
            if (n > 5000) begin check("ready timeout", 32'd0, 32'd1); break; end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #2;
        while (bus0.tx_busy || bus1.tx_busy || bus2.tx_busy ||
               !bus0.tx_ready || !bus1.tx_ready || !bus2.tx_ready) begin
            @(posedge clk); #2;
            n++;
            if (n > 8000) begin check("idle timeout", 32'd0, 32'd1); break; end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Offer one word; t0 is the cycle whose edge starts the start bit.
    // With align set, the start bit edge coincides with an ignored tick so
    // every following bit lasts exactly 64 clk in tick mode 0.
    task automatic send(input logic [7:0] d, input bit align, output int t0);
        int g = 0;
        wait_ready_all();
        if (align) begin
            while (tdiv != 3 && g < 10) begin @(posedge clk); #2; g++; end
        end
        din = d;
        start_all = 1'b1;
        @(posedge clk); #2;
        start_all = 1'b0;
        t0 = cyc + 1;
    endtask

    task automatic pin(input int k, input int t0, input int b, input logic e, input string nm);
        int target;
        target = t0 + 64 * b + 32;
        while (cyc < target) @(negedge clk);
        check(nm, 32'(obs[k][3]), 32'(e));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ta, tb, nd, nr, rx0;
        logic [9:0] a5;
        logic [9:0] x81;

        // Reset before any clock edge, then again mid-idle.
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) check($sformatf("reset outputs dut%0d", k), 32'(obs[k]), 32'hC);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("idle reset outputs dut0", 32'(obs[0]), 32'hC);
        #2 reset = 1'b1;

        // 8N1 frame of 0xA5 with a tick every 4 clk.
        mode = 0;
        nd = d0_done.size();
        nr = d0_rise.size();
        a5 = 10'b11_1010_0101 << 1;
        send(8'hA5, 1'b1, t0);
        for (int b = 0; b < 10; b++) pin(0, t0, b, a5[b], $sformatf("A5 bit %0d", b));
        pin(1, t0, 9, 1'b0, "even parity of A5");
        wait_idle();
        check("A5 busy rise cycle", 32'(d0_rise[nr] - t0), 32'd0);
        check("A5 done count", 32'(d0_done.size() - nd), 32'd1);
        check("A5 done latency", 32'(d0_done[nd] - t0), 32'd640);

        // Parity values.
        send(8'h07, 1'b1, t0);
        pin(2, t0, 8, 1'b0, "odd parity 7-bit 0x07");
        pin(1, t0, 9, 1'b1, "even parity 0x07");
        wait_idle();
        send(8'h00, 1'b1, t0);
        pin(2, t0, 8, 1'b1, "odd parity 7-bit 0x00");
        pin(1, t0, 9, 1'b0, "even parity 0x00");
        wait_idle();

        // Back-to-back frames plus a request made while not ready.
        nd = d0_done.size();
        nr = d0_rise.size();
        send(8'h55, 1'b1, ta);
        send(8'h0F, 1'b0, tb);
        check("ready low with word queued", 32'(bus0.tx_ready), 32'd0);
        din = 8'hEE;
        start_all = 1'b1;
        repeat (3) @(posedge clk);
        #2 start_all = 1'b0;
        check("ready still low after rejected start", 32'(bus0.tx_ready), 32'd0);
        wait_idle();
        check("b2b done count", 32'(d0_done.size() - nd), 32'd2);
        check("b2b frame count", 32'(d0_rise.size() - nr), 32'd2);
        check("b2b gap", 32'(d0_rise[nr + 1] - d0_done[nd]), 32'd1);

        // Reset in the middle of data bit 3 of 0x3C, then a clean frame.
        send(8'h3C, 1'b1, t0);
        while (cyc < t0 + 64 * 4 + 20) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) check($sformatf("mid-frame reset dut%0d", k), 32'(obs[k]), 32'hC);
        #3 reset = 1'b1;
        x81 = 10'b11_1000_0001 << 1;
        send(8'h81, 1'b1, t0);
        pin(0, t0, 1, x81[1], "0x81 bit 1");
        pin(0, t0, 2, x81[2], "0x81 bit 2");
        pin(0, t0, 8, x81[8], "0x81 bit 8");
        wait_idle();

        // Random words, random tick spacing, rejected starts on the load edge.
        mode = 1;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            send(8'($urandom), 1'b0, t0);
            if ($urandom_range(0, 1) == 1) begin
                din = 8'($urandom);
                start_all = 1'b1;
                @(posedge clk); #2;
                start_all = 1'b0;
            end
        end
        wait_idle();

        // Loopback of every byte value with a tick on every clk.
        mode = 2;
        rx0 = rx_count;
        for (int v = 0; v < 256; v++) send(8'(v), 1'b0, t0);
        wait_idle();
        check("loopback word count", 32'(rx_count - rx0), 32'd256);
        check("loopback queue drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts parallel words over a ready/start handshake, frames them (start bit, DATA_BITS data LSB-first, optional parity, stop) and drives the serial line. Bit timing uses the shared 16x-oversampling `s_tick` from the baud generator that also feeds `uart_rx`, so a `uart_tx`/`uart_rx` pair with the same parameters and tick source forms a working link. A one-deep holding register allows the next word to be queued while the current frame shifts out, giving gap-free back-to-back frames.

## Interface
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd. Other values are illegal.
- `STOP_TICKS`, 16: stop duration in `s_tick`s. 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `s_tick` in 1: one-`clk` pulse at 16x the baud rate.
- `tx_start` in 1: request to load `tx_data`. Honoured only when `tx_ready`=1.
- `tx_data` in DATA_BITS: word to send. Sampled on the accept edge.
- `tx_ready` out 1: holding register empty, equal to ~hold_valid. Reset value 1.
- `tx_busy` out 1: high whenever state != IDLE. Reset value 0.
- `tx_done_tick` out 1: one-`clk` pulse at the end of each frame's stop period. Reset value 0.
- `tx` out 1: serial line, registered, idle-high. Reset value 1.

## Operation
- **Holding register:** edge with `tx_start && tx_ready` → hold_data <= `tx_data`, hold_valid <= 1.
  - `tx_start` while `tx_ready`=0 is ignored. There is no error flag.
  - If the holding register empties on the same edge as a rejected request, the request stays rejected, because ready was 0 in that cycle.
- **States:** IDLE, START, DATA, PARITY, STOP. Counters: tick_cnt (5 bits) and bit_cnt (3 bits).
- **IDLE:** `tx`=1.
  - If hold_valid: shift_reg <= hold_data, hold_valid <= 0, tick_cnt <= 0, bit_cnt <= 0, parity accumulator <= 0 (even) or 1 (odd), then → START.
  - Any `s_tick` arriving on this transition edge is not counted.
- **START:** `tx`=0.
  - Each `s_tick` increments tick_cnt.
  - On the `s_tick` with tick_cnt==15: tick_cnt <= 0, → DATA.
- **DATA:** `tx`=shift_reg[0].
  - On the `s_tick` with tick_cnt==15: shift_reg shifts right one position, the parity accumulator XORs in the bit just sent, bit_cnt increments, tick_cnt <= 0.
  - If bit_cnt==DATA_BITS-1: → PARITY when PARITY!=0, otherwise → STOP.
- **PARITY:** `tx`=accumulator, which gives an even or odd count of ones over data plus parity. Lasts 16 ticks, then → STOP.
- **STOP:** `tx`=1.
  - On the `s_tick` with tick_cnt==STOP_TICKS-1: `tx_done_tick` <= 1 for exactly one clock, → IDLE.
- **Back-to-back:** if hold_valid is set when STOP completes, IDLE loads it on the next edge. The line gap is 1 clk, not a full bit.
- `tx` is registered, so it changes on the edge that enters each state or shifts each bit.
- **Reset asserted at any time:** `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done_tick`=0, state IDLE, hold_valid=0, counters 0. Any in-flight frame is truncated and not resumed.

## Timing
- **Accept to start bit:** accept at edge N → IDLE takes the word at edge N+1 → `tx` low and `tx_busy`=1 from edge N+1. `tx_ready` is 0 from N to N+1, then 1 again from N+1.
- **Bit durations:** 16 `s_tick` periods per start, data and parity bit. The stop period is STOP_TICKS `s_tick` periods.
- **Frame length in ticks:** 16·(1+DATA_BITS+(PARITY!=0)) + STOP_TICKS. This is 160 for 8N1.
- `tx_busy` falls on the same edge that `tx_done_tick` pulses. It rises again one edge later if a word is queued.
- `s_tick` may arrive on any cycle, including back-to-back cycles. Each pulse counts once.

## Test plan
1. **Reset:** assert `reset`=0 mid-idle and hold it → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done_tick`=0, checked asynchronously before any clk edge.
2. **8N1 frame:** `s_tick` every 4 clk, send 0xA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 64 clk. Exactly one `tx_done_tick`, 640 clk after the start bit begins.
3. **Parity:** PARITY=1, send 0x07 → parity bit 1. PARITY=2, send 0x07 → parity bit 0. PARITY=1, send 0x00 → parity bit 0.
4. **Back-to-back:**
   - Send 0x55, then send 0x0F while busy → `tx_ready` drops and then rises at the second start bit.
   - The second start bit begins 1 clk after the first `tx_done_tick`.
   - Two `tx_done_tick` pulses total.
   - A third `tx_start` issued while `tx_ready`=0 produces no frame.
5. **Reset mid-frame:** assert reset during data bit 3 of 0x3C → `tx`=1 and `tx_busy`=0 immediately. After release, sending 0x81 produces a clean, complete frame.
6. **Loopback:** connect `tx` to `uart_rx` `rx` with the same `s_tick`, send 256 consecutive values 0x00..0xFF → `rx_data` matches each value and `rx_done_tick` count equals 256.
